// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: timer select encoding used by the CPU decode and
// the timer block, plus the tone-divider helper.
package chip8_pkg;

    localparam logic TIMER_SEL_DELAY = 1'b0;
    localparam logic TIMER_SEL_SOUND = 1'b1;

    localparam int unsigned TIMER_W   = 8;
    localparam int unsigned TONE_CNT_W = 32;

    typedef logic [TIMER_W-1:0]    timer_val_t;
    typedef logic [TONE_CNT_W-1:0] tone_cnt_t;

    // Half-period reload value for a square wave of tone_hz from clock_hz.
    function automatic tone_cnt_t tone_half_top(input int unsigned clock_hz,
                                                input int unsigned tone_hz);
        return tone_cnt_t'(clock_hz / (2 * tone_hz) - 1);
    endfunction

endpackage

// File: rtl/chip8_countdown8.sv
// 8-bit saturating down-counter with synchronous load; load wins over dec.
module chip8_countdown8
    import chip8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  timer_val_t load_val,
    input  logic       dec,
    output timer_val_t value
);

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values and simulation order cannot create races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - timer_val_t'(1);
        end
    end

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers with a 60 Hz countdown and an ST-gated
// square-wave buzzer divided down from the system clock.
module chip8_timers
    import chip8_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 12_000_000,
    parameter int unsigned TONE_HZ  = 440
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_60hz,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       mute,
    output logic [7:0] delay_value,
    output logic       sound_active,
    output logic       beep
);

    localparam tone_cnt_t TONE_HALF_TOP = tone_half_top(CLOCK_HZ, TONE_HZ);

    logic       dt_load;
    logic       st_load;
    timer_val_t st_value;

    assign dt_load = wr_en && (wr_sel == TIMER_SEL_DELAY);
    assign st_load = wr_en && (wr_sel == TIMER_SEL_SOUND);

    chip8_countdown8 u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dt_load),
        .load_val (wr_data),
        .dec      (tick_60hz),
        .value    (delay_value)
    );

    chip8_countdown8 u_sound (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (st_load),
        .load_val (wr_data),
        .dec      (tick_60hz),
        .value    (st_value)
    );

    assign sound_active = (st_value != '0);

    tone_cnt_t tone_cnt;
    tone_cnt_t tone_cnt_nxt;
    logic      beep_phase;
    logic      beep_phase_nxt;

    // Idle holds the divider at its reload value so every burst starts low
    // and rises after exactly TONE_HALF_TOP+1 active cycles.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        tone_cnt_nxt   = TONE_HALF_TOP;
        beep_phase_nxt = 1'b0;
        if (sound_active) begin
            if (tone_cnt == '0) begin
                tone_cnt_nxt   = TONE_HALF_TOP;
                beep_phase_nxt = ~beep_phase;
            end else begin
                tone_cnt_nxt   = tone_cnt - tone_cnt_t'(1);
                beep_phase_nxt = beep_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt   <= TONE_HALF_TOP;
            beep_phase <= 1'b0;
            beep       <= 1'b0;
        end else begin
            tone_cnt   <= tone_cnt_nxt;
            beep_phase <= beep_phase_nxt;
            beep       <= beep_phase & ~mute;
        end
    end

endmodule
